banked_memory: RTL and testbench

BANKED_MEMORY -- requirements
Module: banked_memory

---
 rtl/banked_memory_pkg.sv | 15 +
 rtl/memory_bank.sv | 25 ++
 rtl/banked_memory.sv | 144 ++++++++++++++
 tb/tb_banked_memory.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/banked_memory_pkg.sv
// Shared types and helpers for banked_memory.
package banked_memory_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // Bank-select field width. Never below 1, so a single-bank build
  // still has a legal select signal.
  function automatic int bank_sel_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/memory_bank.sv
// Single-port synchronous RAM with registered read data.
// A write leaves rdata unchanged (no-change mode). Contents are not reset.
module memory_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write or read one word per enabled cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/banked_memory.sv
// Banked word memory with a pipelined read path.
// The upper address bits select the bank and the lower bits select the word within it.
// Optional macro BANKED_MEMORY_CLEAR_EN: after reset, the block sweeps INIT_VALUE
// through every word before it raises init_done.
module banked_memory
  import banked_memory_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    NUM_BANKS  = 4,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done
);

  localparam int BSW   = bank_sel_w(NUM_BANKS);
  localparam int BBITS = $clog2(NUM_BANKS);
  localparam int WAW   = ADDR_WIDTH - BBITS;
  localparam int LAT   = 1 + OUT_REG;

  logic                                 acc, rd_acc;
  logic [BSW-1:0]                       req_bank, bsel_q;
  logic [WAW-1:0]                       req_word;
  logic [NUM_BANKS-1:0]                 bk_en, bk_we;
  logic [WAW-1:0]                       bk_addr;
  logic [DATA_WIDTH-1:0]                bk_wdata;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bk_rdata;
  logic [LAT:1]                         vld_pipe;
  logic [DATA_WIDTH-1:0]                rd_mux, hold_q;
  logic                                 clr_active;
  logic [WAW-1:0]                       clr_addr;

  if (NUM_BANKS > 1) begin : g_bsel
    assign req_bank = req_addr[ADDR_WIDTH-1 -: BBITS];
  end else begin : g_nobsel
    assign req_bank = '0;
  end
  assign req_word = req_addr[WAW-1:0];

`ifdef BANKED_MEMORY_CLEAR_EN
  clr_state_e     state_q, state_d;
  logic [WAW-1:0] cnt_q;

  // Clear-sweep state and word counter. A reset restarts the sweep at word 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Leave CLEAR after the last in-bank word. READY is held until the next reset.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && &cnt_q) state_d = ST_READY;
  end

  assign clr_active = (state_q == ST_CLEAR);
  assign clr_addr   = cnt_q;
  assign init_done  = (state_q == ST_READY);
`else
  assign clr_active = 1'b0;
  assign clr_addr   = '0;
  assign init_done  = 1'b1;
`endif

  assign req_ready = init_done;
  assign acc       = req_valid & req_ready;
  assign rd_acc    = acc & ~req_we;

  // Bank controls. The sweep writes all banks in parallel; otherwise only the selected bank is enabled.
  always_comb begin
    bk_en    = '0;
    bk_we    = '0;
    bk_addr  = req_word;
    bk_wdata = req_wdata;
    if (clr_active) begin
      bk_en    = '1;
      bk_we    = '1;
      bk_addr  = clr_addr;
      bk_wdata = INIT_VALUE;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bk_en[b] = acc & (req_bank == BSW'(b));
        bk_we[b] = acc & req_we & (req_bank == BSW'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    memory_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(WAW)
    ) u_bank (
      .clk  (clk),
      .en   (bk_en[b]),
      .we   (bk_we[b]),
      .addr (bk_addr),
      .wdata(bk_wdata),
      .rdata(bk_rdata[b])
    );
  end

  // Read-valid shift register and the bank select for the read in the RAM output stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      bsel_q   <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      for (int s = 2; s <= LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
      if (rd_acc) bsel_q <= req_bank;
    end
  end

  assign rd_mux = bk_rdata[bsel_q];

  // Last returned word. With OUT_REG it is the output stage; without it, it holds rsp_rdata between responses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          hold_q <= INIT_VALUE;
    else if (vld_pipe[1]) hold_q <= rd_mux;
  end

  if (OUT_REG != 0) begin : g_oreg
    assign rsp_rdata = hold_q;
  end else begin : g_noreg
    assign rsp_rdata = vld_pipe[1] ? rd_mux : hold_q;
  end
  assign rsp_valid = vld_pipe[LAT];

endmodule

// File: tb/tb_banked_memory.sv
// Directed bench: one DUT with OUT_REG=0 and one with OUT_REG=1, both on the same request stream.
// The OUT_REG=1 instance is expected to show the OUT_REG=0 result one cycle later.
module tb_banked_memory;

`ifdef BANKED_MEMORY_CLEAR_EN
  localparam int   EXP_N        = 1024;
  localparam logic EXP_RST_DONE = 1'b0;
`else
  localparam int   EXP_N        = 1;
  localparam logic EXP_RST_DONE = 1'b1;
`endif

  logic        clk = 1'b0, resetn = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [11:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rdy0, rdy1, v0, v1, id0, id1;
  logic [7:0]  d0, d1;
  int          tests = 0, fails = 0;
  logic        pv = 1'b0;
  logic [7:0]  pd = '0;

  always #5 clk = ~clk;

  banked_memory #(.OUT_REG(0)) dut0 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v0), .rsp_rdata(d0), .init_done(id0));

  banked_memory #(.OUT_REG(1)) dut1 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v1), .rsp_rdata(d1), .init_done(id1));

  typedef struct {
    logic       vld;
    logic       we;
    logic [11:0] addr;
    logic [7:0] wdata;
    logic       ev;
    logic [7:0] ed;
  } vec_t;

  vec_t main_tab[19];
  vec_t clr_tab[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one row, clock it and compare. The row's own expectation applies to dut0; dut1 gets the previous row's expectation.
  task automatic apply(input vec_t v, input string tag);
    req_valid = v.vld; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    step();
    chk({tag, " dut0 valid"}, {31'd0, v0}, {31'd0, v.ev});
    chk({tag, " dut0 data"},  {24'd0, d0}, {24'd0, v.ed});
    chk({tag, " dut1 valid"}, {31'd0, v1}, {31'd0, pv});
    chk({tag, " dut1 data"},  {24'd0, d1}, {24'd0, pd});
    pv = v.ev; pd = v.ed;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  // Count cycles from reset release until init_done rises. Any response seen while waiting is stray.
  task automatic wait_init(input logic rd, output int n);
    logic stray;
    n = 0; stray = 1'b0;
    req_valid = rd; req_we = 1'b0; req_addr = '0;
    while (n < 5000) begin
      step();
      n++;
      if (v0 | v1) stray = 1'b1;
      if (id0) break;
    end
    req_valid = 1'b0;
    chk("no response before init_done", {31'd0, stray}, 32'd0);
    chk("dut1 init_done", {31'd0, id1}, 32'd1);
    pv = 1'b0; pd = 8'h00;
  endtask

  initial begin
    int n;
    main_tab[0]  = '{1'b1, 1'b1, 12'h7FF, 8'hA5, 1'b0, 8'h00};
    main_tab[1]  = '{1'b1, 1'b0, 12'h7FF, 8'h00, 1'b1, 8'hA5};
    main_tab[2]  = '{1'b1, 1'b1, 12'h000, 8'h5A, 1'b0, 8'hA5};
    main_tab[3]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'hA5};
    main_tab[4]  = '{1'b1, 1'b1, 12'h010, 8'h11, 1'b0, 8'hA5};
    main_tab[5]  = '{1'b1, 1'b1, 12'h410, 8'h22, 1'b0, 8'hA5};
    main_tab[6]  = '{1'b1, 1'b1, 12'h810, 8'h33, 1'b0, 8'hA5};
    main_tab[7]  = '{1'b1, 1'b1, 12'hC10, 8'h44, 1'b0, 8'hA5};
    main_tab[8]  = '{1'b1, 1'b0, 12'h010, 8'h00, 1'b1, 8'h11};
    main_tab[9]  = '{1'b1, 1'b0, 12'h410, 8'h00, 1'b1, 8'h22};
    main_tab[10] = '{1'b1, 1'b0, 12'h810, 8'h00, 1'b1, 8'h33};
    main_tab[11] = '{1'b1, 1'b0, 12'hC10, 8'h00, 1'b1, 8'h44};
    main_tab[12] = '{1'b1, 1'b0, 12'h000, 8'h00, 1'b1, 8'h5A};
    main_tab[13] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h5A};
    main_tab[14] = '{1'b1, 1'b1, 12'h7FF, 8'h3C, 1'b0, 8'h5A};
    main_tab[15] = '{1'b1, 1'b0, 12'h7FF, 8'h00, 1'b1, 8'h3C};
    main_tab[16] = '{1'b0, 1'b1, 12'h7FF, 8'h99, 1'b0, 8'h3C};
    main_tab[17] = '{1'b1, 1'b0, 12'h7FF, 8'h00, 1'b1, 8'h3C};
    main_tab[18] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h3C};
    clr_tab[0]   = '{1'b1, 1'b0, 12'h000, 8'h00, 1'b1, 8'h00};
    clr_tab[1]   = '{1'b1, 1'b0, 12'h3FF, 8'h00, 1'b1, 8'h00};
    clr_tab[2]   = '{1'b1, 1'b0, 12'h400, 8'h00, 1'b1, 8'h00};
    clr_tab[3]   = '{1'b1, 1'b0, 12'hFFF, 8'h00, 1'b1, 8'h00};
    clr_tab[4]   = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00};

    // Values while reset is held.
    step(); step();
    chk("reset dut0 valid", {31'd0, v0}, 32'd0);
    chk("reset dut1 valid", {31'd0, v1}, 32'd0);
    chk("reset dut0 data",  {24'd0, d0}, 32'd0);
    chk("reset dut1 data",  {24'd0, d1}, 32'd0);
    chk("reset init_done",  {31'd0, id0}, {31'd0, EXP_RST_DONE});
    resetn = 1'b1;

`ifdef BANKED_MEMORY_CLEAR_EN
    wait_init(1'b0, n);
    chk("sweep length", n, EXP_N);
    for (int i = 0; i < 5; i++) apply(clr_tab[i], $sformatf("clr%0d", i));
`else
    chk("init_done at release", {31'd0, id0}, 32'd1);
    chk("req_ready at release", {31'd0, rdy0}, 32'd1);
    chk("dut1 ready at release", {31'd0, rdy1}, 32'd1);
`endif

    for (int i = 0; i < 19; i++) apply(main_tab[i], $sformatf("row%0d", i));

    // Reset lands while the OUT_REG=1 response is still in flight.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h000;
    step();
    req_valid = 1'b0;
    chk("pre-reset dut0 valid", {31'd0, v0}, 32'd1);
    chk("pre-reset dut0 data",  {24'd0, d0}, 32'h5A);
    chk("pre-reset dut1 valid", {31'd0, v1}, 32'd0);
    resetn = 1'b0;
    #1;
    chk("mid-pipe dut0 valid", {31'd0, v0}, 32'd0);
    chk("mid-pipe dut1 valid", {31'd0, v1}, 32'd0);
    chk("mid-pipe dut0 data",  {24'd0, d0}, 32'd0);
    chk("mid-pipe dut1 data",  {24'd0, d1}, 32'd0);
    chk("mid-pipe init_done",  {31'd0, id0}, {31'd0, EXP_RST_DONE});
    step(); step();
    resetn = 1'b1;
    wait_init(1'b0, n);
    chk("post-reset sweep length", n, EXP_N);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no stray dut0 valid", {31'd0, v0}, 32'd0);
      chk("no stray dut1 valid", {31'd0, v1}, 32'd0);
      chk("held dut1 data", {24'd0, d1}, 32'd0);
    end

`ifdef BANKED_MEMORY_CLEAR_EN
    // Reset in cycle 500 of the sweep. A read held during the sweep must not be accepted.
    resetn = 1'b0; step(); step(); resetn = 1'b1;
    for (int i = 0; i < 500; i++) step();
    resetn = 1'b0;
    #1;
    chk("mid-sweep init_done", {31'd0, id0}, 32'd0);
    step();
    resetn = 1'b1;
    wait_init(1'b1, n);
    chk("restarted sweep length", n, EXP_N);
    apply('{1'b1, 1'b0, 12'h7FF, 8'h00, 1'b1, 8'h00}, "swept 0x7FF");
    apply('{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00}, "swept idle");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
